snn_window_scheduler: RTL
=========================

Name: snn_window_scheduler

Overview:
- Sequences the spiking network through fixed-length evaluation windows.
- Per window: obtains fresh sensor samples via ADC handshake, clears network state, enables the network on a fixed number of 20 kHz timesteps, counts output spikes per excitatory neuron and derives a steering command.
- Sits between the ADC front end, the SNN core (its en/rst inputs and Output_spike) and the motor driver, which consumes the command through a valid/ready handshake.

Parameters:
- EXCNUM, 2, number of excitatory output neurons. Decision logic uses indices 0 (left) and 1 (right).
- WINDOW, 200, enabled timesteps per window, ≥1.
- CW, 10, spike counter width.
- MARGIN, 4, minimum count difference required to issue a turn.
- MIN_SPIKES, 2, both counts below this gives CMD_FWD.
- ADC_TIMEOUT, 1000, clk cycles to wait for adc_ack.
- CONTINUOUS, 0, if 1, restart SAMPLE after each handshake without needing start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run one window; honoured only in IDLE
- tick  in  1  one-cycle 20 kHz timestep strobe
- adc_req  out  1  sample request to ADC
- adc_ack  in  1  ADC data valid
- sens_fl, sens_ml, sens_mr, sens_fr  in  12 each  ADC results
- sens_fl_q, sens_ml_q, sens_mr_q, sens_fr_q  out  12 each  latched sensor values driven to the SNN
- snn_rst  out  1  network state clear
- snn_en  out  1  network timestep enable
- spike_in  in  EXCNUM  Output_spike from the SNN
- cnt0, cnt1  out  CW  spike counts of the last completed window
- cmd  out  2  00 STOP, 01 FWD, 10 LEFT, 11 RIGHT
- cmd_err  out  1  command produced by ADC timeout
- cmd_valid  out  1  command valid
- cmd_ready  in  1  motor driver accepts
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal counters = 0.
- FSM states: IDLE, SAMPLE, CLEAR, RUN, DECIDE, OUTPUT.
- IDLE → SAMPLE when start=1, or immediately when CONTINUOUS=1. start in any other state is ignored (no queueing).
- SAMPLE:
  - adc_req=1 and the timeout counter increments each cycle.
  - On the adc_ack cycle: latch all four sens_* into sens_*_q, drop adc_req the next cycle, go to CLEAR.
  - If the counter reaches ADC_TIMEOUT before ack: cmd=STOP, cmd_err=1, go to OUTPUT. sens_*_q keep their old values.
- CLEAR:
  - snn_rst=1 for exactly 1 cycle.
  - Working spike counters and the step counter are zeroed.
  - Go to RUN.
- RUN:
  - snn_en pulses high for one cycle on each tick (snn_en = tick while in RUN).
  - spike_in is sampled in the cycle after each snn_en pulse. Each set bit increments its counter, saturating at 2^CW−1.
  - After the WINDOW-th pulse and its sample cycle, go to DECIDE. Ticks arriving after the WINDOW-th pulse are ignored.
  - A tick coincident with the sample cycle is legal and counted as the next step.
- DECIDE (1 cycle):
  - Copy working counters to cnt0/cnt1.
  - Compute cmd in priority order:
    - both counts < MIN_SPIKES → FWD
    - cnt0 ≥ cnt1 + MARGIN → LEFT
    - cnt1 ≥ cnt0 + MARGIN → RIGHT
    - otherwise FWD
  - Comparisons are unsigned, with width CW+1 to avoid overflow.
  - cmd_err=0. Go to OUTPUT.
- OUTPUT:
  - cmd_valid=1. cmd and cmd_err are held stable until cmd_valid && cmd_ready.
  - On handshake: cmd_valid=0 next cycle. Go to IDLE, or SAMPLE if CONTINUOUS=1.
  - If cmd_ready is high on the first OUTPUT cycle, the handshake completes in that cycle.
- cnt0/cnt1 and cmd hold their values between windows; they are cleared only by rst.
- Reset mid-operation: every state returns to IDLE next edge. snn_en=0 and snn_rst=0.
- Latency with immediate ack and ready: start → adc_req 1 cycle. Last sample → cmd_valid 2 cycles.

Decomposition:
- Shared package snn_pkg:
  - cmd encodings CMD_STOP/FWD/LEFT/RIGHT
  - FSM state enum
  - sensor width constant SENS_W=12
- One sub-module, snn_spike_accum: per-neuron saturating CW-bit counter with clear and sample-enable, instantiated EXCNUM times.

Test Plan:
1. WINDOW=8, start, ack after 3 cycles, spike_in=2'b01 on all 8 steps → cnt0=8, cnt1=0, cmd=LEFT, cmd_valid held until cmd_ready asserted 5 cycles later.
2. spike_in=2'b11 every step, WINDOW=8 → cnt0=cnt1=8, cmd=FWD. Then spikes only 1 step each → both 1 < MIN_SPIKES → FWD.
3. adc_ack never arrives, ADC_TIMEOUT=20 → cmd_valid after 20 SAMPLE cycles with cmd=STOP, cmd_err=1, snn_en never asserted.
4. CW=3, WINDOW=12, spike_in=2'b10 every step → cnt1 saturates at 7, cmd=RIGHT.
5. rst asserted at RUN step 4 → all outputs 0 next cycle, state IDLE. A fresh start completes a normal window. A start pulse during RUN is ignored.
6. CONTINUOUS=1, cmd_ready tied high → back-to-back windows. snn_rst pulses once per window; adc_req re-asserts the cycle after the handshake.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared encodings for the SNN window scheduler: steering commands, FSM states, sensor width.
package snn_pkg;

    localparam int SENS_W = 12;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_LEFT  = 2'b10,
        CMD_RIGHT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CLEAR,
        S_RUN,
        S_DECIDE,
        S_OUTPUT
    } state_e;

endpackage

// File: rtl/snn_spike_accum.sv
// Per-neuron spike counter: cleared at window start, saturates at all-ones.
module snn_spike_accum #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          smp,
    input  logic          spike,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (smp && spike && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snn_window_scheduler.sv
// Window sequencer for the SNN: ADC sample, network clear, WINDOW enabled timesteps,
// per-neuron spike counting and a steering command handed off over valid/ready.
module snn_window_scheduler
    import snn_pkg::*;
#(
    parameter int EXCNUM      = 2,
    parameter int WINDOW      = 200,
    parameter int CW          = 10,
    parameter int MARGIN      = 4,
    parameter int MIN_SPIKES  = 2,
    parameter int ADC_TIMEOUT = 1000,
    parameter int CONTINUOUS  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tick,
    output logic              adc_req,
    input  logic              adc_ack,
    input  logic [SENS_W-1:0] sens_fl,
    input  logic [SENS_W-1:0] sens_ml,
    input  logic [SENS_W-1:0] sens_mr,
    input  logic [SENS_W-1:0] sens_fr,
    output logic [SENS_W-1:0] sens_fl_q,
    output logic [SENS_W-1:0] sens_ml_q,
    output logic [SENS_W-1:0] sens_mr_q,
    output logic [SENS_W-1:0] sens_fr_q,
    output logic              snn_rst,
    output logic              snn_en,
    input  logic [EXCNUM-1:0] spike_in,
    output logic [CW-1:0]     cnt0,
    output logic [CW-1:0]     cnt1,
    output logic [1:0]        cmd,
    output logic              cmd_err,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy
);

    localparam int TW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam int SW = $clog2(WINDOW + 1);
    localparam int XW = CW + 1;

    state_e                        state;
    cmd_e                          cmd_q;
    cmd_e                          decision;
    logic [TW-1:0]                 tcnt;
    logic [SW-1:0]                 steps;
    logic                          smp;
    logic [EXCNUM-1:0][CW-1:0]     wcnt;
    logic [XW-1:0]                 w0;
    logic [XW-1:0]                 w1;

    // Enable follows tick directly so the network sees the strobe in the same cycle;
    // once WINDOW pulses have gone out, further ticks are dropped.
    assign snn_en = (state == S_RUN) && tick && (steps != SW'(WINDOW));
    assign busy   = (state != S_IDLE);
    assign cmd    = cmd_q;

    for (genvar i = 0; i < EXCNUM; i++) begin : g_acc
        snn_spike_accum #(.CW(CW)) u_acc (
            .clk   (clk),
            .rst   (rst),
            .clr   (state == S_CLEAR),
            .smp   (smp),
            .spike (spike_in[i]),
            .cnt   (wcnt[i])
        );
    end

    assign w0 = {1'b0, wcnt[0]};
    assign w1 = {1'b0, wcnt[1]};

    always_comb begin
        decision = CMD_FWD;
        if ((w0 < XW'(MIN_SPIKES)) && (w1 < XW'(MIN_SPIKES))) begin
            decision = CMD_FWD;
        end else if (w0 >= w1 + XW'(MARGIN)) begin
            decision = CMD_LEFT;
        end else if (w1 >= w0 + XW'(MARGIN)) begin
            decision = CMD_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            steps     <= '0;
            smp       <= 1'b0;
            adc_req   <= 1'b0;
            snn_rst   <= 1'b0;
            sens_fl_q <= '0;
            sens_ml_q <= '0;
            sens_mr_q <= '0;
            sens_fr_q <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
            cmd_q     <= CMD_STOP;
            cmd_err   <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            snn_rst <= 1'b0;
            smp     <= snn_en;
            case (state)
                S_IDLE: begin
                    if (start || (CONTINUOUS != 0)) begin
                        state   <= S_SAMPLE;
                        adc_req <= 1'b1;
                        tcnt    <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (adc_ack) begin
                        sens_fl_q <= sens_fl;
                        sens_ml_q <= sens_ml;
                        sens_mr_q <= sens_mr;
                        sens_fr_q <= sens_fr;
                        adc_req   <= 1'b0;
                        snn_rst   <= 1'b1;
                        state     <= S_CLEAR;
                    end else if (tcnt == TW'(ADC_TIMEOUT - 1)) begin
                        adc_req   <= 1'b0;
                        cmd_q     <= CMD_STOP;
                        cmd_err   <= 1'b1;
                        cmd_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    steps <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (snn_en) begin
                        steps <= steps + 1'b1;
                    end
                    // Leave only after the last pulse's spikes have been sampled.
                    if (smp && (steps == SW'(WINDOW))) begin
                        state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    cnt0      <= wcnt[0];
                    cnt1      <= wcnt[1];
                    cmd_q     <= decision;
                    cmd_err   <= 1'b0;
                    cmd_valid <= 1'b1;
                    state     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (CONTINUOUS != 0) begin
                            state   <= S_SAMPLE;
                            adc_req <= 1'b1;
                            tcnt    <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
